uart_tx_arbiter: RTL

- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte requesters.
- Sits between the application producers and the UART transmitter inside the top-level.
- Latches the granted requester's byte and drives the transmitter's start/data inputs.
- Tracks the transmitter's busy handshake, and drives a busy indication suitable for an LED.

---
 rtl/uart_tx_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Optional header-byte pass per grant is enabled by defining UART_ARB_TAG_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   arb_busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT     = 3'd1,
`ifdef UART_ARB_TAG_EN
        ST_TAG       = 3'd2,
`endif
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    // Search last+1, last+2, ... (mod NUM_REQ); MSB of the result is the found flag.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   last);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

`ifdef UART_ARB_TAG_EN
    // Header is the ASCII digit of the served requester.
    function automatic logic [7:0] tag_byte(input logic [IDX_W-1:0] idx);
        return 8'h30 + {{(8-IDX_W){1'b0}}, idx};
    endfunction
`endif

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [7:0]           byte_q, byte_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 arb_busy_q, arb_busy_d;
`ifdef UART_ARB_TAG_EN
    logic                 tag_pass_q, tag_pass_d;
`endif

    logic [IDX_W:0]       pick_s;
    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;

    // Round-robin candidate for the next grant.
    always_comb begin
        pick_s       = rr_pick(req_valid, last_q);
        pick_found_s = pick_s[IDX_W];
        pick_idx_s   = pick_s[IDX_W-1:0];
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        byte_d      = byte_q;
        req_ack_d   = {NUM_REQ{1'b0}};
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
`ifdef UART_ARB_TAG_EN
        tag_pass_d  = tag_pass_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_idx_d = pick_idx_s;
                    state_d     = ST_GRANT;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                byte_d    = req_data[{grant_idx_q, 3'b000} +: 8];
                req_ack_d = idx_onehot(grant_idx_q);
                last_d    = grant_idx_q;
`ifdef UART_ARB_TAG_EN
                state_d   = ST_TAG;
`else
                state_d   = ST_START;
`endif
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG: begin
                tag_pass_d = 1'b1;
                state_d    = ST_START;
            end
`endif
            ST_START: begin
                tx_start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
                if (tag_pass_q) begin
                    tx_data_d = tag_byte(grant_idx_q);
                end else begin
                    tx_data_d = byte_q;
                end
`else
                tx_data_d  = byte_q;
`endif
                state_d    = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    if (tag_pass_q) begin
                        tag_pass_d = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Registered copy of "not idle" so the LED tracks the state exactly.
        arb_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= {IDX_W{1'b0}};
            last_q      <= IDX_W'(NUM_REQ - 1);
            byte_q      <= 8'h00;
            req_ack_q   <= {NUM_REQ{1'b0}};
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            arb_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_q      <= last_d;
            byte_q      <= byte_d;
            req_ack_q   <= req_ack_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            arb_busy_q  <= arb_busy_d;
        end
    end

`ifdef UART_ARB_TAG_EN
    // Marks that the byte in flight is the header rather than the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_pass_q <= 1'b0;
        end else begin
            tag_pass_q <= tag_pass_d;
        end
    end
`endif

    assign req_ack   = req_ack_q;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign grant_idx = grant_idx_q;
    assign arb_busy  = arb_busy_q;

endmodule
